// File: rtl/timer_pkg.sv
// Shared definitions for the down_timer block.
//   state_e         : 2-bit FSM encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   DEF_WIDTH       : default count width
//   DEF_PRESCALE_W  : default prescale field width
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH      = 4;
    localparam int DEF_PRESCALE_W = 4;

endpackage

// File: rtl/prescale_tick.sv
// Prescaler for down_timer: emits a tick every prescale+1 enabled cycles.
//   clk      : clock, rising edge
//   rstn     : async active-low reset
//   en       : advance the prescaler this cycle (counter holds when low)
//   clr      : synchronous clear to 0, overrides en
//   prescale : terminal value of the prescaler
//   tick     : combinational, high in the enabled cycle where the count
//              has reached prescale
module prescale_tick import timer_pkg::*; #(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // >= rather than == so that lowering prescale below the current count
    // mid-run produces a tick instead of a long wrap-around.
    assign tick = en && (cnt_q >= prescale);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting timer with prescaler, pause and
// one-shot / periodic (auto-reload) modes.
//   clk         : clock, rising edge
//   rstn        : async active-low reset
//   load        : load load_val into count and reload register (top priority)
//   load_val    : value to load
//   start       : start / resume counting
//   stop        : pause counting (wins over start)
//   auto_reload : 1 = periodic, 0 = one-shot
//   prescale    : tick every prescale+1 cycles
//   out         : registered current count
//   tc          : registered one-cycle terminal-count pulse (with out==0)
//   busy        : state is RUN
//   done        : state is DONE
module down_timer import timer_pkg::*; #(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      out,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    logic tick;
    logic ps_en;
    logic ps_clr;
    logic restart;

    // Restart from DONE reloads the count; a simultaneous stop cancels it.
    assign restart = (state_q == ST_DONE) && start && !stop;

    // Prescaler only advances while actually running; stop and load freeze it
    // for that cycle so a pause holds its phase.
    assign ps_en  = (state_q == ST_RUN) && !load && !stop;
    assign ps_clr = load || restart;

    prescale_tick #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescale (
        .clk      (clk),
        .rstn     (rstn),
        .en       (ps_en),
        .clr      (ps_clr),
        .prescale (prescale),
        .tick     (tick)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = ST_IDLE;
        end else if (stop) begin
            if (state_q == ST_RUN)
                state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start && (out_q != '0)) state_d = ST_RUN;
                ST_RUN:   if (tick && (out_q == WIDTH'(1)) && !auto_reload)
                              state_d = ST_DONE;
                ST_PAUSE: if (start) state_d = ST_RUN;
                ST_DONE:  if (start) state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_RUN);
        done = (state_q == ST_DONE);
    end

    // ---------------- count datapath ----------------
    // tick already implies RUN with no load/stop this cycle.
    always_comb begin
        out_d    = out_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (load) begin
            out_d    = load_val;
            reload_d = load_val;
        end else if (restart) begin
            out_d = reload_q;
        end else if (tick) begin
            if (out_q == '0) begin
                // Only reachable in periodic mode: the tick after terminal
                // count reloads, giving a period of reload+1 ticks.
                out_d = reload_q;
            end else if (out_q == WIDTH'(1)) begin
                out_d = '0;
                tc_d  = 1'b1;
            end else begin
                out_d = out_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q    <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            out_q    <= out_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer. Expected {out,tc,busy,done} per cycle
// are pushed to a scoreboard queue and popped after each rising edge.
module tb_down_timer;

    localparam int WIDTH      = 4;
    localparam int PRESCALE_W = 4;

    logic                  clk;
    logic                  rstn;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic                  start;
    logic                  stop;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;
    logic [WIDTH-1:0]      out;
    logic                  tc;
    logic                  busy;
    logic                  done;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             tc;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .stop        (stop),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .out         (out),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int o, input bit t, input bit b, input bit d);
        exp_t e;
        e.out  = WIDTH'(o);
        e.tc   = t;
        e.busy = b;
        e.done = d;
        sb.push_back(e);
    endtask

    // One edge per queued entry; sample 1 time unit after the edge.
    task automatic drain(input string name);
        exp_t e, got;
        while (sb.size() > 0) begin
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = {out, tc, busy, done};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s: got out=%0d tc=%b busy=%b done=%b, expected out=%0d tc=%b busy=%b done=%b",
                         name, got.out, got.tc, got.busy, got.done,
                         e.out, e.tc, e.busy, e.done);
            end
        end
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = WIDTH'(v);
        push(v, 0, 0, 0);
        drain("load");
        load = 1'b0;
    endtask

    task automatic test_reset;
        exp_t got;
        // power-on reset state
        rstn = 1'b0;
        #3;
        got = {out, tc, busy, done};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_init: got %h expected 0", got);
        end
        @(negedge clk);
        rstn = 1'b1;
        // mid-RUN reset at out=3
        prescale = '0; auto_reload = 1'b0;
        do_load(5);
        start = 1'b1;
        push(5, 0, 1, 0); drain("rst_run");
        start = 1'b0;
        push(4, 0, 1, 0); push(3, 0, 1, 0); drain("rst_run");
        #2 rstn = 1'b0;
        #1;
        got = {out, tc, busy, done};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h expected 0", got);
        end
        #1 rstn = 1'b1;
        // released: IDLE, stays idle with no stimulus
        push(0, 0, 0, 0); drain("rst_idle");
        // first edge after release responds to load
        do_load(7);
    endtask

    task automatic test_one_shot;
        prescale = '0; auto_reload = 1'b0;
        do_load(5);
        start = 1'b1;
        push(5, 0, 1, 0); drain("oneshot");
        start = 1'b0;
        push(4, 0, 1, 0); push(3, 0, 1, 0); push(2, 0, 1, 0);
        push(1, 0, 1, 0); push(0, 1, 0, 1); push(0, 0, 0, 1);
        drain("oneshot");
    endtask

    task automatic test_auto_reload;
        prescale = '0; auto_reload = 1'b1;
        do_load(3);
        start = 1'b1;
        push(3, 0, 1, 0); drain("autorl");
        start = 1'b0;
        push(2, 0, 1, 0); push(1, 0, 1, 0); push(0, 1, 1, 0);
        push(3, 0, 1, 0); push(2, 0, 1, 0); push(1, 0, 1, 0); push(0, 1, 1, 0);
        push(3, 0, 1, 0);
        drain("autorl");
        auto_reload = 1'b0;
    endtask

    task automatic test_prescale;
        prescale = PRESCALE_W'(2); auto_reload = 1'b0;
        do_load(2);
        start = 1'b1;
        push(2, 0, 1, 0); drain("prescale");
        start = 1'b0;
        push(2, 0, 1, 0); push(2, 0, 1, 0);
        push(1, 0, 1, 0); push(1, 0, 1, 0); push(1, 0, 1, 0);
        push(0, 1, 0, 1);
        drain("prescale");
    endtask

    task automatic test_pause;
        prescale = '0; auto_reload = 1'b0;
        do_load(4);
        start = 1'b1;
        push(4, 0, 1, 0); drain("pause");
        start = 1'b0;
        push(3, 0, 1, 0); push(2, 0, 1, 0); drain("pause");
        stop = 1'b1;
        for (int i = 0; i < 4; i++) push(2, 0, 0, 0);
        drain("pause_hold");
        stop = 1'b0; start = 1'b1;
        push(2, 0, 1, 0); drain("pause_resume");
        start = 1'b0;
        push(1, 0, 1, 0); push(0, 1, 0, 1); drain("pause_resume");
        // start+stop together in RUN -> PAUSE, no decrement
        do_load(3);
        start = 1'b1;
        push(3, 0, 1, 0); drain("startstop");
        stop = 1'b1;
        push(3, 0, 0, 0); push(3, 0, 0, 0); drain("startstop");
        start = 1'b0; stop = 1'b0;
    endtask

    // Prescaler phase must survive a pause.
    task automatic test_prescale_resume;
        prescale = PRESCALE_W'(2); auto_reload = 1'b0;
        do_load(3);
        start = 1'b1;
        push(3, 0, 1, 0); drain("ps_resume");
        start = 1'b0;
        push(3, 0, 1, 0); drain("ps_resume");
        stop = 1'b1;
        push(3, 0, 0, 0); drain("ps_resume");
        stop = 1'b0; start = 1'b1;
        push(3, 0, 1, 0); drain("ps_resume");
        start = 1'b0;
        push(3, 0, 1, 0); push(2, 0, 1, 0); drain("ps_resume");
    endtask

    task automatic test_load_zero;
        prescale = '0; auto_reload = 1'b0;
        do_load(5);
        start = 1'b1;
        push(5, 0, 1, 0); drain("load_run");
        start = 1'b0;
        push(4, 0, 1, 0); drain("load_run");
        // load wins over start in RUN
        load = 1'b1; load_val = WIDTH'(9); start = 1'b1;
        push(9, 0, 0, 0); drain("load_run");
        load = 1'b0; start = 1'b0;
        do_load(0);
        start = 1'b1;
        push(0, 0, 0, 0); push(0, 0, 0, 0); drain("zero_start");
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
        auto_reload = 1'b0; prescale = '0;
        test_reset;
        test_one_shot;
        test_auto_reload;
        test_prescale;
        test_pause;
        test_prescale_resume;
        test_load_zero;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the count width.
REQ-002 The block SHALL have parameter PRESCALE_W, default 4, which sets the prescale field width.
REQ-003 Port clk SHALL be input, width 1: the single clock, rising-edge active.
REQ-004 Port rstn SHALL be input, width 1: reset, asynchronous and active-low.
REQ-005 Port load SHALL be input, width 1: load load_val into the count and the reload register.
REQ-006 Port load_val SHALL be input, width WIDTH: the value to load.
REQ-007 Port start SHALL be input, width 1: start or resume counting.
REQ-008 Port stop SHALL be input, width 1: pause counting.
REQ-009 Port auto_reload SHALL be input, width 1: 1 selects periodic mode, 0 selects one-shot mode.
REQ-010 Port prescale SHALL be input, width PRESCALE_W: ticks occur every prescale+1 clk cycles.
REQ-011 Port out SHALL be output, width WIDTH: the current count (registered).
REQ-012 Port tc SHALL be output, width 1: a one-cycle terminal-count pulse (registered).
REQ-013 Port busy SHALL be output, width 1: high while in the RUN state.
REQ-014 Port done SHALL be output, width 1: high while in the DONE state.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE and DONE.
REQ-016 load SHALL take priority over start and stop in every state: at the next edge, out=load_val, reload register=load_val, prescaler=0, state=IDLE, tc=0.
REQ-017 start in IDLE SHALL move the state to RUN at the next edge when out!=0; when out==0, start SHALL be ignored.
REQ-018 start in DONE SHALL, at the next edge, set out to the reload register, clear the prescaler and move the state to RUN.
REQ-019 start in PAUSE SHALL move the state to RUN at the next edge, with the prescaler resuming from its held value.
REQ-020 start in RUN SHALL be ignored.
REQ-021 stop in RUN SHALL move the state to PAUSE at the next edge, holding both out and the prescaler.
REQ-022 stop in any state other than RUN SHALL be ignored.
REQ-023 When start and stop are asserted in the same cycle, stop SHALL win (RUN goes to PAUSE; other states are unchanged).
REQ-024 In RUN the prescaler SHALL count up each cycle; a tick SHALL occur when prescaler>=prescale, and the prescaler SHALL then return to 0. The >= compare makes a prescale lowered mid-run safe.
REQ-025 With prescale=0, a tick SHALL occur every cycle; the first decrement SHALL occur one edge after the state becomes RUN.
REQ-026 On a tick with out>1, out SHALL decrement by 1 (modulo 2^WIDTH arithmetic; underflow is never reached).
REQ-027 On a tick with out==1, out SHALL become 0 and tc SHALL be 1 for exactly that one cycle, coincident with out==0.
REQ-028 In the same out==1 tick case, the state SHALL move to DONE if auto_reload=0 and SHALL remain RUN if auto_reload=1.
REQ-029 On a tick in RUN with out==0 (auto-reload mode), out SHALL be set to the reload register, giving a period of reload+1 ticks; tc SHALL remain 0 on that tick.
REQ-030 auto_reload SHALL be sampled on each tick; changing it mid-run SHALL affect only the next terminal count.
REQ-031 In DONE, out SHALL hold 0.
REQ-032 In IDLE and PAUSE, out and tc=0 SHALL hold.
REQ-033 busy and done SHALL be decoded directly from the state register, with no extra latency.

Reset
REQ-034 rstn=0 SHALL immediately, asynchronously force out=0, tc=0, reload register=0, prescaler=0 and state=IDLE (so busy=0 and done=0).
REQ-035 Reset SHALL take effect at any point, including mid-RUN or mid-PAUSE.
REQ-036 After rstn is released, the block SHALL respond to load or start from the first rising edge.

Structure
REQ-037 The state encoding (2-bit IDLE=0, RUN=1, PAUSE=2, DONE=3) and the default WIDTH and PRESCALE_W constants SHALL live in the shared package timer_pkg.
REQ-038 The prescaler SHALL be the sub-module prescale_tick, with ports clk, rstn, en, clr, prescale and tick.
REQ-039 The FSM and the count datapath SHALL stay in down_timer.

Verification
REQ-040 Scenario 1 SHALL check reset: assert rstn=0 mid-RUN at out=3 -> out=0, tc=0 and busy=0 with no clock edge; after release, state is IDLE.
REQ-041 Scenario 2 SHALL check one-shot mode: load 5, prescale=0, auto_reload=0, start -> out 5,4,3,2,1,0 on successive cycles; tc=1 only with out=0; then done=1 and busy=0.
REQ-042 Scenario 3 SHALL check auto-reload: load 3, auto_reload=1, prescale=0, start -> out 3,2,1,0,3,2,1,0; tc pulses every 4 cycles; busy stays 1.
REQ-043 Scenario 4 SHALL check the prescaler: load 2, prescale=2, start -> each value is held 3 cycles; tc asserts exactly 6 cycles after RUN entry+1.
REQ-044 Scenario 5 SHALL check pause and priority: stop at out=2 for 4 cycles -> out holds 2 and busy=0; start -> out resumes 1, then 0. Then start and stop together in RUN -> PAUSE.
REQ-045 Scenario 6 SHALL check load and zero-start: load 9 during RUN -> next cycle out=9, IDLE, busy=0. Then load 0 followed by start -> start is ignored, state stays IDLE, out=0.
